// File: rtl/round_defs.sv
// Shared definitions for the FP multiply datapath: widths, rounding modes
// and the mantissa multiplier FSM state.
package round_defs;
  localparam int MANT_W     = 24;
  localparam int PROD_W     = 2 * MANT_W;
  localparam int RND_MANT_W = MANT_W + 1;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} mmn_state_t;
endpackage

// File: rtl/mant_normalize.sv
// Combinational normalizer: maps a raw significand product in [0,4) to the
// rounder's {mantissa, guard, sticky} view plus the exponent bump.
module mant_normalize #(
  parameter int MANT_W = 24
) (
  input  logic [2*MANT_W-1:0] prod,
  output logic [MANT_W:0]     mant,
  output logic                guard,
  output logic                sticky,
  output logic                exp_inc
);

  // Top bit set means the product landed in [2,4); drop one extra bit.
  always_comb begin
    mant    = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    exp_inc = 1'b0;
    if (prod[2*MANT_W-1]) begin
      mant    = {1'b0, prod[2*MANT_W-1 -: MANT_W]};
      guard   = prod[MANT_W-1];
      sticky  = |prod[MANT_W-2:0];
      exp_inc = 1'b1;
    end else begin
      mant    = {1'b0, prod[2*MANT_W-2 -: MANT_W]};
      guard   = prod[MANT_W-2];
      sticky  = |prod[MANT_W-3:0];
      exp_inc = 1'b0;
    end
  end

endmodule

// File: rtl/mant_mult_norm.sv
// Sequential radix-2 shift-add significand multiplier followed by a one-cycle
// normalization stage, with valid/ready handshakes on both sides.
module mant_mult_norm
  import round_defs::*;
#(
  parameter int MANT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] a_mant,
  input  logic [MANT_W-1:0] b_mant,
  input  logic              a_sign,
  input  logic              b_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W:0]   mant_out,
  output logic              guard,
  output logic              sticky,
  output logic              sign_out,
  output logic              exp_inc
);

  localparam int CW = $clog2(MANT_W);

  mmn_state_t          state;
  logic [MANT_W:0]     acc;
  logic [MANT_W-1:0]   mplr;
  logic [MANT_W-1:0]   mcand;
  logic [CW-1:0]       cnt;
  logic                sign_q;

  logic [MANT_W:0]     sum;
  logic [2*MANT_W-1:0] prod;
  logic [MANT_W:0]     n_mant;
  logic                n_guard;
  logic                n_sticky;
  logic                n_exp_inc;

  assign sum  = {1'b0, acc[MANT_W-1:0]} + {1'b0, mcand};
  assign prod = {acc[MANT_W-1:0], mplr};

  // Handshake flags depend on state only; reset masks in_ready immediately.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  mant_normalize #(.MANT_W(MANT_W)) u_norm (
    .prod    (prod),
    .mant    (n_mant),
    .guard   (n_guard),
    .sticky  (n_sticky),
    .exp_inc (n_exp_inc)
  );

  // The 49-bit {acc, mplr} register shifts right every MUL cycle so the low
  // multiplier bit always selects whether to add the multiplicand.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      mplr     <= '0;
      mcand    <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      mant_out <= '0;
      guard    <= 1'b0;
      sticky   <= 1'b0;
      sign_out <= 1'b0;
      exp_inc  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= b_mant;
            mplr   <= a_mant;
            acc    <= '0;
            cnt    <= '0;
            sign_q <= a_sign ^ b_sign;
            state  <= MUL;
          end
        end
        MUL: begin
          if (mplr[0]) begin
            {acc, mplr} <= {1'b0, sum, mplr[MANT_W-1:1]};
          end else begin
            {acc, mplr} <= {1'b0, acc, mplr[MANT_W-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(MANT_W - 1)) begin
            state <= NORM;
          end
        end
        NORM: begin
          mant_out <= n_mant;
          guard    <= n_guard;
          sticky   <= n_sticky;
          exp_inc  <= n_exp_inc;
          sign_out <= sign_q;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mant_mult_norm.sv
// Directed and randomized checks of mant_mult_norm against an arithmetic
// reference model of the significand product and its normalization.
module tb_mant_mult_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] a_mant = '0;
  logic [23:0] b_mant = '0;
  logic        a_sign = 1'b0;
  logic        b_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] mant_out;
  logic        guard;
  logic        sticky;
  logic        sign_out;
  logic        exp_inc;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mant_mult_norm #(.MANT_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .a_sign    (a_sign),
    .b_sign    (b_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .guard     (guard),
    .sticky    (sticky),
    .sign_out  (sign_out),
    .exp_inc   (exp_inc)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: exact integer product, then pick the window by magnitude.
  function automatic void refModel(input logic [23:0] a, input logic [23:0] b,
                                   output logic [24:0] m, output logic g,
                                   output logic s, output logic e);
    longint unsigned la, lb, p;
    la = a;
    lb = b;
    p  = la * lb;
    if (p >= 64'h8000_0000_0000) begin
      m = 25'(p / (64'd1 << 24));
      g = ((p / (64'd1 << 23)) % 2) == 1;
      s = (p % (64'd1 << 23)) != 0;
      e = 1'b1;
    end else begin
      m = 25'(p / (64'd1 << 23));
      g = ((p / (64'd1 << 22)) % 2) == 1;
      s = (p % (64'd1 << 22)) != 0;
      e = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b,
                               input logic sa, input logic sb);
    int waited = 0;
    while (!in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("ready_timeout", {63'd0, in_ready}, 64'd1);
    a_mant   = a;
    b_mant   = b;
    a_sign   = sa;
    b_sign   = sb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_latency"}, 64'(k), 64'd25);
  endtask

  task automatic checkBundle(input string tag, input logic [24:0] m, input logic g,
                             input logic s, input logic e, input logic sg);
    checkOutput({tag, "_valid"},  {63'd0, out_valid}, 64'd1);
    checkOutput({tag, "_mant"},   64'(mant_out), 64'(m));
    checkOutput({tag, "_guard"},  {63'd0, guard},   {63'd0, g});
    checkOutput({tag, "_sticky"}, {63'd0, sticky},  {63'd0, s});
    checkOutput({tag, "_expinc"}, {63'd0, exp_inc}, {63'd0, e});
    checkOutput({tag, "_sign"},   {63'd0, sign_out}, {63'd0, sg});
    checkOutput({tag, "_busy"},   {63'd0, in_ready}, 64'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_ready_after"}, {63'd0, in_ready}, 64'd1);
    checkOutput({tag, "_valid_after"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic [24:0] em;
    logic        eg, es, ee;
    logic [23:0] ra, rb;
    logic        rsa, rsb;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_mant", 64'(mant_out), 64'd0);
    checkOutput("rst_flags", {59'd0, guard, sticky, sign_out, exp_inc, 1'b0}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", {63'd0, in_ready}, 64'd1);

    // 1.0 x 1.0
    applyStimulus(24'h800000, 24'h800000, 1'b0, 1'b0);
    waitResult("one");
    checkBundle("one", 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("one");

    // max x max
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1);
    waitResult("max");
    checkBundle("max", 25'h0FFFFFE, 1'b0, 1'b1, 1'b1, 1'b0);
    handshake("max");

    // Tie case with mixed signs
    applyStimulus(24'h800001, 24'hC00000, 1'b1, 1'b0);
    waitResult("tie");
    checkBundle("tie", 25'h0C00001, 1'b1, 1'b0, 1'b0, 1'b1);
    handshake("tie");

    // 1.5 x 1.5 held under backpressure with a stray in_valid pulse
    applyStimulus(24'hC00000, 24'hC00000, 1'b0, 1'b1);
    waitResult("bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_mant   = 24'h123456;
        b_mant   = 24'h654321;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checkBundle($sformatf("bp_hold%0d", i), 25'h0900000, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    in_valid = 1'b0;
    handshake("bp");
    @(negedge clk);
    checkOutput("bp_no_restart", {63'd0, out_valid}, 64'd0);
    checkOutput("bp_idle", {63'd0, in_ready}, 64'd1);

    // Reset in the middle of MUL
    applyStimulus(24'hFFFFFF, 24'hAAAAAA, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mrst_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("mrst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mrst_mant", 64'(mant_out), 64'd0);
    checkOutput("mrst_flags", {60'd0, guard, sticky, sign_out, exp_inc}, 64'd0);
    @(negedge clk);
    applyStimulus(24'h800000, 24'h800000, 1'b0, 1'b0);
    waitResult("after_rst");
    checkBundle("after_rst", 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("after_rst");

    // Zero operand
    applyStimulus(24'h000000, 24'hABCDEF, 1'b0, 1'b1);
    waitResult("zero");
    checkBundle("zero", 25'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    handshake("zero");

    // Randomized operands, mostly normalized, some with the hidden bit clear
    for (int n = 0; n < 24; n++) begin
      ra  = 24'($urandom);
      rb  = 24'($urandom);
      if ($urandom_range(0, 3) != 0) ra[23] = 1'b1;
      if ($urandom_range(0, 3) != 0) rb[23] = 1'b1;
      rsa = 1'($urandom);
      rsb = 1'($urandom);
      refModel(ra, rb, em, eg, es, ee);
      applyStimulus(ra, rb, rsa, rsb);
      waitResult($sformatf("rnd%0d", n));
      checkBundle($sformatf("rnd%0d", n), em, eg, es, ee, rsa ^ rsb);
      handshake($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
